instr_fetch: RTL and testbench

//  Fetch stage feeding decode_instr: reads 64-bit instructions from a 32-bit instruction memory as two word

---
 rtl/dec_pkg.sv | 30 +++
 rtl/instr_fetch_fifo.sv | 87 ++++++++
 rtl/instr_fetch.sv | 139 +++++++++++++
 tb/tb_instr_fetch.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/dec_pkg.sv
// Shared types for the fetch/decode front end.
// Widths, fetch FSM states and the queued fetch entry.
package dec_pkg;

    localparam int INSTR_W = 64;
    localparam int WORD_W  = 32;
    localparam int PC_W    = 64;
    localparam int ENTRY_W = PC_W + INSTR_W;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

    function automatic logic [PC_W-1:0] align8(input logic [PC_W-1:0] a);
        return {a[PC_W-1:3], 3'b000};
    endfunction

    function automatic logic [PC_W-1:0] hi_addr(input logic [PC_W-1:0] a);
        return {a[PC_W-1:3], 3'b100};
    endfunction

endpackage

// File: rtl/instr_fetch_fifo.sv
// Synchronous FIFO of assembled fetch entries.
// Push and pop may coincide, including when full; flush empties it.
module fetch_fifo
    import dec_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int W     = ENTRY_W,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          flush_i,
    input  logic [W-1:0]  data_i,
    output logic [W-1:0]  data_o,
    output logic [CW-1:0] cnt_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_q, wr_d;
    logic [PW-1:0] rd_q, rd_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty_o = (cnt_q == '0);
    assign full_o  = (cnt_q == CW'(DEPTH));
    assign cnt_o   = cnt_q;
    assign data_o  = mem_q[rd_q];

    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (do_push) begin
            wr_d = inc(wr_q);
        end
        if (do_pop) begin
            rd_d = inc(rd_q);
        end
        unique case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 1'b1;
            2'b01:   cnt_d = cnt_q - 1'b1;
            default: cnt_d = cnt_q;
        endcase
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: two 32-bit beats per 64-bit instruction, queued for decode.
// Redirects flush the queue; an in-flight request is drained in DROP.
module instr_fetch
    import dec_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'h0,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        fetch_en_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc_i,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    output logic [63:0] instr_o,
    output logic [63:0] instr_pc_o
);

    localparam int CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t        state_q, state_d;
    logic [PC_W-1:0]     pc_q, pc_d;
    logic [PC_W-1:0]     addr_q, addr_d;
    logic [WORD_W-1:0]   low_q, low_d;

    logic                push;
    logic                xfer;
    logic                room_after;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CW-1:0]       fifo_cnt;
    fetch_entry_t        push_ent;
    fetch_entry_t        head_ent;
    logic [ENTRY_W-1:0]  head_raw;

    assign xfer          = instr_valid_o && instr_ready_i;
    assign instr_valid_o = !fifo_empty;
    assign mem_req_o     = (state_q != IDLE);
    assign mem_addr_o    = addr_q;

    assign push_ent.pc    = pc_q;
    assign push_ent.instr = {mem_rdata_i, low_q};
    assign head_ent       = head_raw;
    assign instr_o        = head_ent.instr;
    assign instr_pc_o     = head_ent.pc;

    // Room once this cycle's push and pop have both landed.
    assign room_after = xfer ? !fifo_full
                             : (fifo_cnt < CW'(FIFO_DEPTH - 1));

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        addr_d  = addr_q;
        low_d   = low_q;
        push    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (fetch_en_i && !fifo_full) begin
                    state_d = LO;
                    addr_d  = pc_q;
                end
            end
            LO: begin
                if (mem_ack_i) begin
                    low_d   = mem_rdata_i;
                    state_d = HI;
                    addr_d  = hi_addr(pc_q);
                end
            end
            HI: begin
                if (mem_ack_i) begin
                    push = 1'b1;
                    pc_d = pc_q + 64'd8;
                    if (fetch_en_i && room_after) begin
                        state_d = LO;
                        addr_d  = pc_q + 64'd8;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            DROP: begin
                if (mem_ack_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // A live request cannot be withdrawn, so it is drained in DROP.
        if (redirect_i) begin
            push   = 1'b0;
            pc_d   = align8(redirect_pc_i);
            addr_d = addr_q;
            low_d  = low_q;
            if (state_q == IDLE || mem_ack_i) begin
                state_d = IDLE;
            end else begin
                state_d = DROP;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
            addr_q  <= '0;
            low_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            addr_q  <= addr_d;
            low_q   <= low_d;
        end
    end

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (ENTRY_W)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (push),
        .pop_i   (xfer),
        .flush_i (redirect_i),
        .data_i  (push_ent),
        .data_o  (head_raw),
        .cnt_o   (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios plus randomized traffic
// checked against a transaction-level model of the fetch queue.
module tb_instr_fetch;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        fetch_en_i = 1'b0;
    logic        redirect_i = 1'b0;
    logic [63:0] redirect_pc_i = '0;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_ack_i = 1'b0;
    logic [31:0] mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic [63:0] instr_o;
    logic [63:0] instr_pc_o;

    int n_vec = 0;
    int n_err = 0;
    int n_xfer = 0;

    always #5 clk = ~clk;

    instr_fetch #(
        .RESET_PC   (64'h0),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_i),
        .fetch_en_i    (fetch_en_i),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .mem_req_o     (mem_req_o),
        .mem_addr_o    (mem_addr_o),
        .mem_ack_i     (mem_ack_i),
        .mem_rdata_i   (mem_rdata_i),
        .instr_valid_o (instr_valid_o),
        .instr_ready_i (instr_ready_i),
        .instr_o       (instr_o),
        .instr_pc_o    (instr_pc_o)
    );

    function automatic logic [31:0] word(input logic [63:0] a);
        return a[31:0] ^ a[63:32] ^ 32'hA5A5_0000;
    endfunction

    assign mem_rdata_i = word(mem_addr_o);

    task automatic chk64(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk64(nm, {63'd0, act}, {63'd0, exp});
    endtask

    // Reference model: expected queue, fetch pointer and beat phase.
    logic [127:0] q[$];
    logic [63:0]  mpc = '0;
    bit           half = 0;
    bit           drop = 0;
    bit           armed = 0;
    bit           in_rst = 0;
    bit           prev_req = 0;
    bit           prev_ack = 0;
    logic [63:0]  prev_addr = '0;

    always @(negedge clk) begin
        if (armed) begin
            if (in_rst) begin
                chk1("rst_req", mem_req_o, 1'b0);
                chk64("rst_addr", mem_addr_o, 64'h0);
                chk1("rst_valid", instr_valid_o, 1'b0);
                chk64("rst_instr", instr_o, 64'h0);
                chk64("rst_pc", instr_pc_o, 64'h0);
            end else begin
                chk1("valid", instr_valid_o, q.size() != 0);
                if (q.size() != 0) begin
                    chk64("head_pc", instr_pc_o, q[0][127:64]);
                    chk64("head_instr", instr_o, q[0][63:0]);
                end
                if (prev_req && !prev_ack) begin
                    chk1("req_hold", mem_req_o, 1'b1);
                    chk64("addr_hold", mem_addr_o, prev_addr);
                end
                if (mem_req_o && !drop) begin
                    chk64("fetch_addr", mem_addr_o, mpc + (half ? 64'd4 : 64'd0));
                end
            end
        end
        armed = 1;
        if (rst_i) begin
            q.delete();
            mpc = 64'h0;
            half = 0;
            drop = 0;
            prev_req = 0;
            prev_ack = 0;
            in_rst = 1;
        end else begin
            in_rst = 0;
            if (q.size() != 0 && instr_ready_i) begin
                void'(q.pop_front());
                n_xfer++;
            end
            if (mem_req_o && mem_ack_i && !redirect_i) begin
                if (drop) begin
                    drop = 0;
                end else if (!half) begin
                    half = 1;
                end else begin
                    chk1("fifo_room", q.size() < DEPTH, 1'b1);
                    q.push_back({mpc, word(mpc + 64'd4), word(mpc)});
                    mpc = mpc + 64'd8;
                    half = 0;
                end
            end
            if (redirect_i) begin
                q.delete();
                mpc = {redirect_pc_i[63:3], 3'b000};
                half = 0;
                drop = mem_req_o && !mem_ack_i;
            end
            prev_req = mem_req_o;
            prev_ack = mem_ack_i;
            prev_addr = mem_addr_o;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    int hold = 0;

    task automatic rand_drive(input bit delayed);
        fetch_en_i = ($urandom_range(0, 9) != 0);
        instr_ready_i = ($urandom_range(0, 9) < 6);
        if (delayed) begin
            mem_ack_i = mem_req_o && (hold == 3);
            hold = (mem_ack_i || !mem_req_o) ? 0 : hold + 1;
        end else begin
            mem_ack_i = $urandom_range(0, 1);
        end
        redirect_i = ($urandom_range(0, 39) == 0);
        redirect_pc_i = {$urandom, $urandom};
        if ($urandom_range(0, 3) == 0) begin
            redirect_pc_i = 64'hFFFF_FFFF_FFFF_FFF3;
        end
        rst_i = ($urandom_range(0, 299) == 0);
    endtask

    initial begin
        // Streaming from reset, ack and ready always high.
        rst_i = 1; fetch_en_i = 1; mem_ack_i = 1; instr_ready_i = 1;
        repeat (2) step();
        rst_i = 0;
        step();
        chk1("t1_req", mem_req_o, 1'b1);
        chk64("t1_a0", mem_addr_o, 64'h0);
        step();
        chk64("t1_a1", mem_addr_o, 64'h4);
        chk1("t1_v0", instr_valid_o, 1'b0);
        step();
        chk64("t1_a2", mem_addr_o, 64'h8);
        chk1("t1_v1", instr_valid_o, 1'b1);
        chk64("t1_pc0", instr_pc_o, 64'h0);
        chk64("t1_i0", instr_o, 64'hA5A50004_A5A50000);
        step();
        chk64("t1_a3", mem_addr_o, 64'hC);
        step();
        chk64("t1_pc8", instr_pc_o, 64'h8);
        chk64("t1_i8", instr_o, 64'hA5A5000C_A5A50008);
        // Back-pressure fills the queue and stalls fetch.
        instr_ready_i = 0;
        repeat (6) step();
        chk1("t2_idle", mem_req_o, 1'b0);
        chk64("t2_head", instr_pc_o, 64'h8);
        instr_ready_i = 1;
        step();
        chk1("t2_still", mem_req_o, 1'b0);
        chk64("t2_next", instr_pc_o, 64'h10);
        instr_ready_i = 0;
        step();
        chk1("t2_resume", mem_req_o, 1'b1);
        chk64("t2_addr", mem_addr_o, 64'h18);
        // Slow memory: every beat acked after three wait cycles.
        hold = 0;
        repeat (300) begin
            rand_drive(1);
            rst_i = 0;
            redirect_i = 0;
            step();
        end
        // Redirect while the high beat is outstanding.
        rst_i = 1; mem_ack_i = 0; instr_ready_i = 1; fetch_en_i = 1;
        redirect_i = 0;
        step();
        rst_i = 0;
        step();
        chk64("t4_a0", mem_addr_o, 64'h0);
        mem_ack_i = 1;
        step();
        chk64("t4_a4", mem_addr_o, 64'h4);
        mem_ack_i = 0;
        step();
        redirect_i = 1; redirect_pc_i = 64'h107;
        step();
        chk1("t4_dreq", mem_req_o, 1'b1);
        chk64("t4_daddr", mem_addr_o, 64'h4);
        redirect_i = 0;
        step();
        mem_ack_i = 1;
        step();
        chk1("t4_idle", mem_req_o, 1'b0);
        step();
        chk64("t4_a100", mem_addr_o, 64'h100);
        step();
        chk64("t4_a104", mem_addr_o, 64'h104);
        step();
        chk64("t4_pc", instr_pc_o, 64'h100);
        chk64("t4_instr", instr_o, 64'hA5A50104_A5A50100);
        // Redirect coinciding with the high-beat ack and a pop.
        instr_ready_i = 0;
        step();
        redirect_i = 1; redirect_pc_i = 64'h200; instr_ready_i = 1;
        step();
        chk1("t5_valid", instr_valid_o, 1'b0);
        chk1("t5_req", mem_req_o, 1'b0);
        redirect_i = 0;
        step();
        chk64("t5_addr", mem_addr_o, 64'h200);
        // Reset while a low-beat request is pending.
        rst_i = 1; mem_ack_i = 0;
        step();
        chk1("t6_req", mem_req_o, 1'b0);
        rst_i = 0; mem_ack_i = 1;
        step();
        chk64("t6_addr", mem_addr_o, 64'h0);
        // Unconstrained random traffic.
        repeat (3000) begin
            rand_drive(0);
            step();
        end
        rst_i = 0; redirect_i = 0;
        step();
        step();
        chk1("progress", n_xfer > 200, 1'b1);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
